// File: rtl/rf_port_arbiter_pkg.sv
// Shared types and default sizes for the register-file port arbiter.
package rf_port_arbiter_pkg;

    localparam int AW_DEFAULT = 4;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Bundle of requester, response and register-file signals around the arbiter.
interface rf_port_arbiter_if
    import rf_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
);

    logic          clr_req;

    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_aaddr;
    logic [AW-1:0] req0_baddr;
    logic          req0_we;
    logic [AW-1:0] req0_waddr;
    logic [DW-1:0] req0_wdata;

    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_aaddr;
    logic [AW-1:0] req1_baddr;
    logic          req1_we;
    logic [AW-1:0] req1_waddr;
    logic [DW-1:0] req1_wdata;

    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_a;
    logic [DW-1:0] rsp_b;

    logic [AW-1:0] rf_Aaddr;
    logic [AW-1:0] rf_Baddr;
    logic [AW-1:0] rf_Caddr;
    logic [DW-1:0] rf_C;
    logic          rf_load;
    logic          rf_nClear;
    logic [DW-1:0] rf_A;
    logic [DW-1:0] rf_B;

    logic          busy;

    // Arbiter side
    modport slave (
        input  clr_req,
        input  req0_valid, req0_aaddr, req0_baddr, req0_we, req0_waddr, req0_wdata,
        input  req1_valid, req1_aaddr, req1_baddr, req1_we, req1_waddr, req1_wdata,
        input  rf_A, rf_B,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_a, rsp_b,
        output rf_Aaddr, rf_Baddr, rf_Caddr, rf_C, rf_load, rf_nClear,
        output busy
    );

    // Requester / register-file side
    modport master (
        output clr_req,
        output req0_valid, req0_aaddr, req0_baddr, req0_we, req0_waddr, req0_wdata,
        output req1_valid, req1_aaddr, req1_baddr, req1_we, req1_waddr, req1_wdata,
        output rf_A, rf_B,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_a, rsp_b,
        input  rf_Aaddr, rf_Baddr, rf_Caddr, rf_C, rf_load, rf_nClear,
        input  busy
    );

endinterface

// File: rtl/rf_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    // Pick a winner: on a tie the requester not granted last wins, a lone request always wins
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Track the last granted requester; reset points at req1 so req0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt_o) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Arbitrates two requesters onto a 2-read/1-write register file and
// sequences the register-file clear after reset and on request.
module rf_port_arbiter
    import rf_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic             clk,
    input  logic             nClear,
    rf_port_arbiter_if.slave bus
);

    state_e        state_q;
    state_e        state_d;
    logic          grantEn;
    logic          busyCmb;
    logic          rfClearN;

    logic [1:0]    gnt;
    logic          xfer;
    logic          winner;

    logic [AW-1:0] selA;
    logic [AW-1:0] selB;
    logic [AW-1:0] selCaddr;
    logic [DW-1:0] selC;
    logic          selWe;

    logic [AW-1:0] heldA_q;
    logic [AW-1:0] heldB_q;
    logic          rspValid_q;
    logic          rspId_q;

    // State register; reset always restarts with the INIT clear cycle
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the status outputs; grants only in RUN when no clear is requested
    always_comb begin
        state_d  = state_q;
        grantEn  = 1'b0;
        busyCmb  = 1'b1;
        rfClearN = 1'b0;
        case (state_q)
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                busyCmb  = 1'b0;
                rfClearN = 1'b1;
                if (bus.clr_req) begin
                    state_d = CLEAR;
                end else begin
                    grantEn = 1'b1;
                end
            end
            CLEAR: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (nClear),
        .req_i ({bus.req1_valid, bus.req0_valid}),
        .en_i  (grantEn),
        .gnt_o (gnt)
    );

    assign xfer   = |gnt;
    assign winner = gnt[1];

    // Steer the winning requester's payload toward the register file
    always_comb begin
        selA     = bus.req0_aaddr;
        selB     = bus.req0_baddr;
        selCaddr = bus.req0_waddr;
        selC     = bus.req0_wdata;
        selWe    = bus.req0_we;
        if (winner) begin
            selA     = bus.req1_aaddr;
            selB     = bus.req1_baddr;
            selCaddr = bus.req1_waddr;
            selC     = bus.req1_wdata;
            selWe    = bus.req1_we;
        end
    end

    // Remember the last read addresses so idle cycles keep the read ports stable
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            heldA_q <= '0;
            heldB_q <= '0;
        end else if (xfer) begin
            heldA_q <= selA;
            heldB_q <= selB;
        end
    end

    // Response tag trails the transfer by one cycle to line up with the registered read data
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            rspValid_q <= 1'b0;
            rspId_q    <= 1'b0;
        end else begin
            rspValid_q <= xfer;
            if (xfer) begin
                rspId_q <= winner;
            end
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    assign bus.rf_Aaddr   = xfer ? selA : heldA_q;
    assign bus.rf_Baddr   = xfer ? selB : heldB_q;
    assign bus.rf_Caddr   = selCaddr;
    assign bus.rf_C       = selC;
    assign bus.rf_load    = xfer & selWe;
    assign bus.rf_nClear  = rfClearN;
    assign bus.busy       = busyCmb;

    assign bus.rsp_valid  = rspValid_q;
    assign bus.rsp_id     = rspId_q;
    assign bus.rsp_a      = bus.rf_A;
    assign bus.rsp_b      = bus.rf_B;

endmodule
